// File: rtl/mux_pkg.sv
// Shared constants for the 8:1 lane selector and its mux tree.
// Lane arrays are typed at each use site because their element width is a module parameter.
package mux_pkg;

  localparam int unsigned N_IN  = 8;
  localparam int unsigned SEL_W = 3;

endpackage

// File: rtl/mux2_1.sv
// WIDTH-bit 2:1 primitive; every bit is steered by the same select.
module mux2_1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux4_1.sv
// WIDTH-bit 4:1 stage: two 2:1 primitives on sel[0] feed a third on sel[1].
module mux4_1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [3:0][WIDTH-1:0] in,
  input  logic [1:0]            sel,
  output logic [WIDTH-1:0]      out
);

  logic [WIDTH-1:0] pair_lo;
  logic [WIDTH-1:0] pair_hi;

  mux2_1 #(.WIDTH(WIDTH)) u_pair_lo (
    .in0 (in[0]),
    .in1 (in[1]),
    .sel (sel[0]),
    .out (pair_lo)
  );

  mux2_1 #(.WIDTH(WIDTH)) u_pair_hi (
    .in0 (in[2]),
    .in1 (in[3]),
    .sel (sel[0]),
    .out (pair_hi)
  );

  mux2_1 #(.WIDTH(WIDTH)) u_final (
    .in0 (pair_lo),
    .in1 (pair_hi),
    .sel (sel[1]),
    .out (out)
  );

endmodule

// File: rtl/mux8_to_1.sv
// 8-input WIDTH-bit selector built as a 4:1/4:1/2:1 tree, with an optional
// enable-gated output register cleared asynchronously by rst_n.
module mux8_to_1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [N_IN-1:0][WIDTH-1:0] in,
  input  logic [SEL_W-1:0]           sel,
  output logic [WIDTH-1:0]           out
);

  typedef logic [N_IN/2-1:0][WIDTH-1:0] half_lanes_t;

  half_lanes_t      lanes_lo;
  half_lanes_t      lanes_hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] mux_c;

  assign lanes_lo = in[3:0];
  assign lanes_hi = in[7:4];

  mux4_1 #(.WIDTH(WIDTH)) u_lo (
    .in  (lanes_lo),
    .sel (sel[1:0]),
    .out (lo)
  );

  mux4_1 #(.WIDTH(WIDTH)) u_hi (
    .in  (lanes_hi),
    .sel (sel[1:0]),
    .out (hi)
  );

  mux2_1 #(.WIDTH(WIDTH)) u_top (
    .in0 (lo),
    .in1 (hi),
    .sel (sel[2]),
    .out (mux_c)
  );

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] out_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
      end else if (en) begin
        out_q <= mux_c;
      end
    end

    assign out = out_q;
  end else begin : g_comb
    // Control inputs have no function without the register.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, en};
    assign out         = mux_c;
  end

endmodule

// File: tb/tb_mux8_to_1.sv
// Self-checking bench: combinational W=1 and W=8 selectors plus a registered W=1 selector,
// each result checked against a scoreboard entry pushed when its stimulus was driven.
module tb_mux8_to_1;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic [7:0]      in_b;
  logic [2:0]      sel;
  logic [7:0][7:0] in_w;
  logic [2:0]      sel_w;
  logic [0:0]      out_c;
  logic [0:0]      out_r;
  logic [7:0]      out_w;

  int n_tests;
  int n_fail;
  logic [7:0] exp_q[$];
  logic [7:0] exp;
  logic       model_r;

  mux8_to_1 #(.WIDTH(1), .REG_OUT(1'b0)) u_dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in    (in_b),
    .sel   (sel),
    .out   (out_c)
  );

  mux8_to_1 #(.WIDTH(1), .REG_OUT(1'b1)) u_dut_r (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in    (in_b),
    .sel   (sel),
    .out   (out_r)
  );

  mux8_to_1 #(.WIDTH(8), .REG_OUT(1'b0)) u_dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in    (in_w),
    .sel   (sel_w),
    .out   (out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_r(input string name);
    exp = exp_q.pop_front();
    n_tests++;
    if (out_r !== exp[0]) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, out_r, exp[0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    in_b  = 8'hCA;
    sel   = 3'd3;
    #2;
    exp_q.push_back(8'h00);
    check_r("reset_async");
    en = 1'b1;
    tick();
    exp_q.push_back(8'h00);
    check_r("reset_held_edge");
    // Release with en low: the first edge must not load.
    rst_n = 1'b1;
    en    = 1'b0;
    tick();
    exp_q.push_back(8'h00);
    check_r("reset_release_no_en");
  endtask

  task automatic test_comb(input logic [7:0] data, input string name);
    in_b = data;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      exp_q.push_back({7'd0, data[s]});
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (out_c !== exp[0]) begin
        n_fail++;
        $display("FAIL %s sel=%0d: got %b expected %b", name, s, out_c, exp[0]);
      end
    end
  endtask

  task automatic test_wide();
    for (int k = 0; k < 8; k++) in_w[k] = 8'h10 + 8'(k);
    for (int s = 0; s < 8; s++) begin
      sel_w = 3'(s);
      exp_q.push_back(8'h10 + 8'(s));
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (out_w !== exp) begin
        n_fail++;
        $display("FAIL wide sel=%0d: got %h expected %h", s, out_w, exp);
      end
    end
    // Distinct per-bit patterns across lanes.
    for (int k = 0; k < 8; k++) in_w[k] = 8'(1 << k) ^ 8'hA5;
    for (int s = 0; s < 8; s++) begin
      sel_w = 3'(7 - s);
      exp_q.push_back(8'(1 << (7 - s)) ^ 8'hA5);
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (out_w !== exp) begin
        n_fail++;
        $display("FAIL wide_bits sel=%0d: got %h expected %h", 7 - s, out_w, exp);
      end
    end
  endtask

  task automatic test_reg_load();
    en   = 1'b1;
    in_b = 8'hCA;
    sel  = 3'd3;
    exp_q.push_back(8'h01);
    #1;
    n_tests++;
    if (out_r !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_latency: got %b expected 0 before edge", out_r);
    end
    tick();
    check_r("reg_sel3");
    sel = 3'd4;
    exp_q.push_back(8'h00);
    tick();
    check_r("reg_sel4");
    sel = 3'd3;
    exp_q.push_back(8'h01);
    tick();
    check_r("reg_reload");
    // Mid-cycle reset clears without a clock edge.
    #2;
    rst_n = 1'b0;
    exp_q.push_back(8'h00);
    #1;
    check_r("reg_midcycle_reset");
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    tick();
    exp_q.push_back(8'h00);
    check_r("reg_after_reset_no_en");
  endtask

  task automatic test_hold();
    en   = 1'b1;
    in_b = 8'hCA;
    sel  = 3'd6;
    exp_q.push_back(8'h01);
    tick();
    check_r("hold_load6");
    en   = 1'b0;
    sel  = 3'd0;
    in_b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h01);
      tick();
      check_r($sformatf("hold_edge%0d", i));
    end
    en = 1'b1;
    exp_q.push_back(8'h00);
    tick();
    check_r("hold_release");
  endtask

  task automatic test_back_to_back();
    en   = 1'b1;
    in_b = 8'hCA;
    sel  = 3'd1;
    exp_q.push_back(8'h01);
    tick();
    check_r("b2b_first");
    in_b = 8'h35;
    sel  = 3'd2;
    exp_q.push_back(8'h01);
    tick();
    check_r("b2b_simultaneous");
    model_r = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_b = 8'($urandom);
      sel  = 3'($urandom_range(0, 7));
      en   = 1'($urandom_range(0, 3) != 0);
      if (en) model_r = in_b[sel];
      exp_q.push_back({7'd0, model_r});
      tick();
      check_r($sformatf("b2b_rand%0d", i));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    in_w    = '0;
    sel_w   = '0;
    test_reset();
    test_comb(8'hCA, "comb_CA");
    test_comb(8'h35, "comb_35");
    test_wide();
    @(negedge clk);
    test_reg_load();
    test_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
